// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed BCD 7-segment display:
// active-low segment patterns ({g,f,e,d,c,b,a}) and the digit-index type.
`timescale 1ns/1ps
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef logic [1:0] dig_idx_t;

  localparam dig_idx_t DIG_UNITS    = 2'd0;
  localparam dig_idx_t DIG_TENS     = 2'd1;
  localparam dig_idx_t DIG_HUNDREDS = 2'd2;

endpackage

// File: rtl/bcd_disp_to_seg.sv
// Combinational nibble-to-segment decoder; non-decimal nibbles show a dash,
// and the blank flag overrides everything with all segments off.
`timescale 1ns/1ps
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    if (blank) begin
      seg_n = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0: seg_n = SEG_0;
        4'd1: seg_n = SEG_1;
        4'd2: seg_n = SEG_2;
        4'd3: seg_n = SEG_3;
        4'd4: seg_n = SEG_4;
        4'd5: seg_n = SEG_5;
        4'd6: seg_n = SEG_6;
        4'd7: seg_n = SEG_7;
        4'd8: seg_n = SEG_8;
        4'd9: seg_n = SEG_9;
        default: seg_n = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Three-digit scanned 7-segment driver with a one-word pending buffer that is
// only copied into the display register at a frame boundary.
`timescale 1ns/1ps
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bcd_valid,
  input  logic [11:0] bcd_in,
  output logic        bcd_ready,
  output logic [6:0]  seg_n,
  output logic [2:0]  an_n,
  output logic        digit_err
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] presc_reg;
  dig_idx_t      idx_reg;
  logic [11:0]   disp_reg;
  logic [11:0]   pend_reg;
  logic          pend_full_reg;

  logic          tc;
  logic          apply;
  logic          accept;
  logic [2:0]    blank;
  logic [2:0]    nib_err;
  logic [6:0]    dig_seg [3];
  logic [6:0]    seg_next;
  logic [2:0]    an_next;

  assign tc        = (presc_reg == PW'(CLK_DIV - 1));
  assign apply     = tc && (idx_reg == DIG_HUNDREDS);
  assign bcd_ready = !pend_full_reg;
  assign accept    = bcd_valid && !pend_full_reg;

  // Tens is only a leading zero when hundreds is zero too; units always shows.
  assign blank[0] = 1'b0;
  assign blank[1] = BLANK_LZ && (disp_reg[11:8] == 4'd0) && (disp_reg[7:4] == 4'd0);
  assign blank[2] = BLANK_LZ && (disp_reg[11:8] == 4'd0);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
      bcd_to_seg u_dec (
        .nibble (disp_reg[4*gi +: 4]),
        .blank  (blank[gi]),
        .seg_n  (dig_seg[gi])
      );
      assign nib_err[gi] = (disp_reg[4*gi +: 4] > 4'd9);
    end
  endgenerate

  always_comb begin
    seg_next = dig_seg[0];
    an_next  = 3'b110;
    case (idx_reg)
      DIG_TENS: begin
        seg_next = dig_seg[1];
        an_next  = 3'b101;
      end
      DIG_HUNDREDS: begin
        seg_next = dig_seg[2];
        an_next  = 3'b011;
      end
      default: begin
        seg_next = dig_seg[0];
        an_next  = 3'b110;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      idx_reg   <= DIG_UNITS;
    end else if (tc) begin
      presc_reg <= '0;
      idx_reg   <= (idx_reg == DIG_HUNDREDS) ? DIG_UNITS : idx_reg + 2'd1;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // Accept and apply never coincide: accepting needs an empty pending slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg      <= 12'h000;
      pend_reg      <= 12'h000;
      pend_full_reg <= 1'b0;
    end else if (apply && pend_full_reg) begin
      disp_reg      <= pend_reg;
      pend_full_reg <= 1'b0;
    end else if (accept) begin
      pend_reg      <= bcd_in;
      pend_full_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n     <= SEG_BLANK;
      an_n      <= 3'b111;
      digit_err <= 1'b0;
    end else begin
      seg_n     <= seg_next;
      an_n      <= an_next;
      digit_err <= |nib_err;
    end
  end

endmodule
